// File: rtl/floo_eos_pkg.sv
// Shared types and width helpers for the end-of-simulation monitor.
package floo_eos_pkg;

  typedef enum logic [2:0] {
    EosIdle,
    EosRun,
    EosSettle,
    EosDone,
    EosTimeout
  } eos_state_e;

  // Index width for addressing n clusters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/floo_eos_monitor.sv
// Sticky collector for per-cluster end-of-sim flags with a settle delay,
// a RUN-phase watchdog and completion statistics.
module floo_eos_monitor
  import floo_eos_pkg::*;
#(
  parameter int unsigned NumClusters   = 32,
  parameter int unsigned SettleCycles  = 100,
  parameter int unsigned TimeoutCycles = 1000000,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic                                 clear_i,
  input  logic [NumClusters-1:0]               eos_i,
  output logic [NumClusters-1:0]               done_mask_o,
  output logic [cnt_width(NumClusters)-1:0]    num_done_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 timeout_o,
  output logic [CntWidth-1:0]                  cycles_o,
  output logic [CntWidth-1:0]                  last_done_cycle_o,
  output logic [idx_width(NumClusters)-1:0]    last_cluster_o
);

  localparam int unsigned IdxW = idx_width(NumClusters);
  localparam int unsigned NumW = cnt_width(NumClusters);
  localparam int unsigned SetW = cnt_width(SettleCycles);

  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);
  localparam logic [SetW-1:0]     SettleLoad  = SetW'(SettleCycles - 1);

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Trailing-zero count: index of the lowest set bit, 0 when none is set.
  function automatic logic [IdxW-1:0] lowest_set(input logic [NumClusters-1:0] v);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = NumClusters - 1; i >= 0; i--) begin
      if (v[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

  function automatic logic [NumW-1:0] popcount(input logic [NumClusters-1:0] v);
    logic [NumW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NumClusters; i++) begin
      cnt = cnt + NumW'(v[i]);
    end
    return cnt;
  endfunction

  eos_state_e             state_q, state_d;
  logic [NumClusters-1:0] mask_q, mask_d;
  logic [CntWidth-1:0]    cycles_q, cycles_d;
  logic [CntWidth-1:0]    last_done_q, last_done_d;
  logic [IdxW-1:0]        last_cluster_q, last_cluster_d;
  logic [SetW-1:0]        settle_q, settle_d;
  logic                   busy_q, done_q, timeout_q;

  logic [NumClusters-1:0] mask_all;
  logic [NumClusters-1:0] new_bits;
  logic                   complete;
  logic                   timeout_hit;

  assign mask_all    = mask_q | eos_i;
  assign new_bits    = eos_i & ~mask_q;
  assign complete    = &mask_all;
  assign timeout_hit = (TimeoutCycles != 0) && (cycles_q == TimeoutLast);

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    cycles_d       = cycles_q;
    last_done_d    = last_done_q;
    last_cluster_d = last_cluster_q;
    settle_d       = settle_q;

    case (state_q)
      EosIdle: begin
        if (start_i) state_d = EosRun;
      end
      EosRun: begin
        mask_d = mask_all;
        // Completion outranks the watchdog; the counter freezes on exit.
        if (complete) begin
          last_done_d    = cycles_q;
          last_cluster_d = lowest_set(new_bits);
          if (SettleCycles == 0) begin
            state_d = EosDone;
          end else begin
            state_d  = EosSettle;
            settle_d = SettleLoad;
          end
        end else if (timeout_hit) begin
          state_d = EosTimeout;
        end else begin
          cycles_d = sat_inc(cycles_q);
        end
      end
      EosSettle: begin
        if (settle_q == '0) state_d = EosDone;
        else                settle_d = settle_q - 1'b1;
      end
      default: ;
    endcase

    if (clear_i) begin
      state_d        = EosIdle;
      mask_d         = '0;
      cycles_d       = '0;
      last_done_d    = '0;
      last_cluster_d = '0;
      settle_d       = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= EosIdle;
      mask_q         <= '0;
      cycles_q       <= '0;
      last_done_q    <= '0;
      last_cluster_q <= '0;
      settle_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      cycles_q       <= cycles_d;
      last_done_q    <= last_done_d;
      last_cluster_q <= last_cluster_d;
      settle_q       <= settle_d;
      busy_q         <= (state_d == EosRun) || (state_d == EosSettle);
      done_q         <= (state_d == EosDone);
      timeout_q      <= (state_d == EosTimeout);
    end
  end

  assign done_mask_o       = mask_q;
  assign num_done_o        = popcount(mask_q);
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign timeout_o         = timeout_q;
  assign cycles_o          = cycles_q;
  assign last_done_cycle_o = last_done_q;
  assign last_cluster_o    = last_cluster_q;

endmodule

// File: tb/tb_floo_eos_monitor.sv
// Directed bench: vector table for the basic completion flow plus
// hand-written sequences for timeout, pulses, pre-set flags and reset.
module tb_floo_eos_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, clear_a = 1'b0;
  logic [3:0]  eos_a = '0;
  logic [3:0]  mask_a;
  logic [2:0]  nd_a;
  logic        busy_a, done_a, tmo_a;
  logic [31:0] cyc_a, ldc_a;
  logic [1:0]  lcl_a;

  logic        start_b = 1'b0, clear_b = 1'b0;
  logic [3:0]  eos_b = '0;
  logic [3:0]  mask_b;
  logic [2:0]  nd_b;
  logic        busy_b, done_b, tmo_b;
  logic [31:0] cyc_b, ldc_b;
  logic [1:0]  lcl_b;

  floo_eos_monitor #(
    .NumClusters(4), .SettleCycles(3), .TimeoutCycles(10), .CntWidth(32)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .clear_i(clear_a), .eos_i(eos_a),
    .done_mask_o(mask_a), .num_done_o(nd_a), .busy_o(busy_a), .done_o(done_a),
    .timeout_o(tmo_a), .cycles_o(cyc_a), .last_done_cycle_o(ldc_a), .last_cluster_o(lcl_a)
  );

  floo_eos_monitor #(
    .NumClusters(4), .SettleCycles(0), .TimeoutCycles(0), .CntWidth(32)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .clear_i(clear_b), .eos_i(eos_b),
    .done_mask_o(mask_b), .num_done_o(nd_b), .busy_o(busy_b), .done_o(done_b),
    .timeout_o(tmo_b), .cycles_o(cyc_b), .last_done_cycle_o(ldc_b), .last_cluster_o(lcl_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start, clear;
    logic [3:0]  eos;
    logic        busy, done, tmo;
    logic [3:0]  mask;
    logic [2:0]  nd;
    logic [31:0] cyc, ldc;
    logic [1:0]  lcl;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic s, input logic c, input logic [3:0] e,
                              input logic b, input logic d, input logic t,
                              input logic [3:0] m, input logic [2:0] n,
                              input logic [31:0] cy, input logic [31:0] ld,
                              input logic [1:0] lc);
    vec_t v;
    v.start = s; v.clear = c; v.eos = e; v.busy = b; v.done = d; v.tmo = t;
    v.mask = m; v.nd = n; v.cyc = cy; v.ldc = ld; v.lcl = lc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic b, input logic d, input logic t,
                       input logic [3:0] m, input logic [2:0] n, input logic [31:0] cy,
                       input logic [31:0] ld, input logic [1:0] lc);
    check({tag, ".busy"}, 32'(busy_a), 32'(b));
    check({tag, ".done"}, 32'(done_a), 32'(d));
    check({tag, ".timeout"}, 32'(tmo_a), 32'(t));
    check({tag, ".mask"}, 32'(mask_a), 32'(m));
    check({tag, ".num_done"}, 32'(nd_a), 32'(n));
    check({tag, ".cycles"}, cyc_a, cy);
    check({tag, ".last_done"}, ldc_a, ld);
    check({tag, ".last_cluster"}, 32'(lcl_a), 32'(lc));
  endtask

  task automatic chk_b(input string tag, input logic b, input logic d, input logic [3:0] m,
                       input logic [31:0] cy, input logic [31:0] ld, input logic [1:0] lc);
    check({tag, ".busy"}, 32'(busy_b), 32'(b));
    check({tag, ".done"}, 32'(done_b), 32'(d));
    check({tag, ".timeout"}, 32'(tmo_b), 32'd0);
    check({tag, ".mask"}, 32'(mask_b), 32'(m));
    check({tag, ".cycles"}, cyc_b, cy);
    check({tag, ".last_done"}, ldc_b, ld);
    check({tag, ".last_cluster"}, 32'(lcl_b), 32'(lc));
  endtask

  task automatic step_a(input logic s, input logic c, input logic [3:0] e);
    start_a = s; clear_a = c; eos_a = e;
    @(posedge clk); #1;
    start_a = 1'b0; clear_a = 1'b0;
  endtask

  task automatic step_b(input logic s, input logic c, input logic [3:0] e);
    start_b = s; clear_b = c; eos_b = e;
    @(posedge clk); #1;
    start_b = 1'b0; clear_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Start, flags 0..2 at RUN cycle 2, flag 3 at cycle 5, settle 3, then start ignored and clear+start.
    tbl[0]  = mk(1, 0, 4'h0, 1, 0, 0, 4'h0, 3'd0, 32'd0, 32'd0, 2'd0);
    tbl[1]  = mk(0, 0, 4'h0, 1, 0, 0, 4'h0, 3'd0, 32'd1, 32'd0, 2'd0);
    tbl[2]  = mk(0, 0, 4'h0, 1, 0, 0, 4'h0, 3'd0, 32'd2, 32'd0, 2'd0);
    tbl[3]  = mk(0, 0, 4'h7, 1, 0, 0, 4'h7, 3'd3, 32'd3, 32'd0, 2'd0);
    tbl[4]  = mk(0, 0, 4'h0, 1, 0, 0, 4'h7, 3'd3, 32'd4, 32'd0, 2'd0);
    tbl[5]  = mk(0, 0, 4'h0, 1, 0, 0, 4'h7, 3'd3, 32'd5, 32'd0, 2'd0);
    tbl[6]  = mk(0, 0, 4'h8, 1, 0, 0, 4'hF, 3'd4, 32'd5, 32'd5, 2'd3);
    tbl[7]  = mk(0, 0, 4'h0, 1, 0, 0, 4'hF, 3'd4, 32'd5, 32'd5, 2'd3);
    tbl[8]  = mk(0, 0, 4'h0, 1, 0, 0, 4'hF, 3'd4, 32'd5, 32'd5, 2'd3);
    tbl[9]  = mk(0, 0, 4'h0, 0, 1, 0, 4'hF, 3'd4, 32'd5, 32'd5, 2'd3);
    tbl[10] = mk(1, 0, 4'h0, 0, 1, 0, 4'hF, 3'd4, 32'd5, 32'd5, 2'd3);
    tbl[11] = mk(1, 1, 4'h0, 0, 0, 0, 4'h0, 3'd0, 32'd0, 32'd0, 2'd0);

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_a("reset_a", 0, 0, 0, 4'h0, 3'd0, 32'd0, 32'd0, 2'd0);
    chk_b("reset_b", 0, 0, 4'h0, 32'd0, 32'd0, 2'd0);

    for (int i = 0; i < 12; i++) begin
      step_a(tbl[i].start, tbl[i].clear, tbl[i].eos);
      chk_a($sformatf("tbl%0d", i), tbl[i].busy, tbl[i].done, tbl[i].tmo, tbl[i].mask,
            tbl[i].nd, tbl[i].cyc, tbl[i].ldc, tbl[i].lcl);
    end

    // Watchdog: only flags 0 and 1 ever arrive.
    step_a(1, 0, 4'h0);
    for (int n = 0; n < 9; n++) begin
      step_a(0, 0, 4'h3);
      check($sformatf("tmo_run%0d.timeout", n), 32'(tmo_a), 32'd0);
      check($sformatf("tmo_run%0d.cycles", n), cyc_a, 32'(n + 1));
    end
    step_a(0, 0, 4'h3);
    chk_a("tmo_hit", 0, 0, 1, 4'h3, 3'd2, 32'd9, 32'd0, 2'd0);
    step_a(0, 0, 4'h3);
    chk_a("tmo_hold", 0, 0, 1, 4'h3, 3'd2, 32'd9, 32'd0, 2'd0);
    step_a(0, 1, 4'h0);
    chk_a("tmo_clear", 0, 0, 0, 4'h0, 3'd0, 32'd0, 32'd0, 2'd0);

    // Last flag exactly at the watchdog limit: completion wins.
    step_a(1, 0, 4'h0);
    for (int n = 0; n < 9; n++) step_a(0, 0, 4'h0);
    check("edge_pre.cycles", cyc_a, 32'd9);
    step_a(0, 0, 4'hF);
    chk_a("edge_cmpl", 1, 0, 0, 4'hF, 3'd4, 32'd9, 32'd9, 2'd0);
    for (int n = 0; n < 2; n++) begin
      step_a(0, 0, 4'h0);
      chk_a($sformatf("edge_settle%0d", n), 1, 0, 0, 4'hF, 3'd4, 32'd9, 32'd9, 2'd0);
    end
    step_a(0, 0, 4'h0);
    chk_a("edge_done", 0, 1, 0, 4'hF, 3'd4, 32'd9, 32'd9, 2'd0);
    step_a(0, 1, 4'h0);

    // Single-cycle pulses, bits 1 and 2 together in the final cycle, eos dropped in SETTLE.
    step_a(1, 0, 4'h0);
    step_a(0, 0, 4'h1);
    step_a(0, 0, 4'h0);
    step_a(0, 0, 4'h8);
    chk_a("pulse_mid", 1, 0, 0, 4'h9, 3'd2, 32'd3, 32'd0, 2'd0);
    step_a(0, 0, 4'h6);
    chk_a("pulse_cmpl", 1, 0, 0, 4'hF, 3'd4, 32'd3, 32'd3, 2'd1);
    step_a(0, 0, 4'h0);
    step_a(0, 0, 4'h0);
    check("pulse_settle.done", 32'(done_a), 32'd0);
    step_a(0, 0, 4'h0);
    chk_a("pulse_done", 0, 1, 0, 4'hF, 3'd4, 32'd3, 32'd3, 2'd1);
    step_a(0, 1, 4'h0);

    // Flags high before start with no settle delay.
    step_b(0, 0, 4'hF);
    chk_b("pre_idle", 0, 0, 4'h0, 32'd0, 32'd0, 2'd0);
    step_b(1, 0, 4'hF);
    chk_b("pre_run", 1, 0, 4'h0, 32'd0, 32'd0, 2'd0);
    step_b(0, 0, 4'hF);
    chk_b("pre_done", 0, 1, 4'hF, 32'd0, 32'd0, 2'd0);
    check("pre_done.num_done", 32'(nd_b), 32'd4);
    step_b(0, 1, 4'h0);
    chk_b("pre_clear", 0, 0, 4'h0, 32'd0, 32'd0, 2'd0);

    // Asynchronous reset in the middle of SETTLE, then a fresh run.
    step_a(1, 0, 4'h0);
    step_a(0, 0, 4'hF);
    step_a(0, 0, 4'h0);
    check("arst_pre.busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_a("arst_now", 0, 0, 0, 4'h0, 3'd0, 32'd0, 32'd0, 2'd0);
    #1 rst_n = 1'b1;
    step_a(1, 0, 4'h0);
    chk_a("arst_restart", 1, 0, 0, 4'h0, 3'd0, 32'd0, 32'd0, 2'd0);
    step_a(0, 0, 4'hF);
    for (int n = 0; n < 3; n++) step_a(0, 0, 4'h0);
    chk_a("arst_done", 0, 1, 0, 4'hF, 3'd4, 32'd0, 32'd0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
